// File: rtl/spi_command_framer.sv
// spi_command_framer
// Turns SPI transactions (chip-select framing plus received bytes) into
// graphics command-bus signals. The first byte of a transaction is the op-code
// and is held valid for the whole transaction. Every later byte is strobed out
// as an operand with a 1-based running count. Each transaction ends with one
// drain cycle, so the last operand is always seen while the op-code is valid.

module spi_command_framer #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   cs_active_in,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid_in,
  output logic [7:0]             op_code_out,
  output logic                   op_code_valid_out,
  output logic [7:0]             operand_out,
  output logic                   operand_valid_out,
  output logic [COUNT_WIDTH-1:0] operand_count_out,
  output logic                   stray_byte_out,
  output logic                   count_overflow_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPCODE  = 2'd1;
  localparam logic [1:0] ST_OPERAND = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sync_fill_r;
  logic                   cs_sync_s;
  logic                   sync_ready_s;
  logic                   cnt_full_s;

  logic [1:0]             state_r;
  logic                   armed_r;
  logic [7:0]             op_code_r;
  logic                   op_code_valid_r;
  logic [7:0]             operand_r;
  logic                   operand_valid_r;
  logic [COUNT_WIDTH-1:0] operand_count_r;
  logic                   stray_byte_r;
  logic                   count_overflow_r;

  // Bring the asynchronous chip-select level into clock_in. A parallel fill
  // marker records when the chain holds real pin samples rather than the
  // zeros left by reset, so those zeros are never mistaken for a CS drop.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      cs_sync_r   <= {SYNC_STAGES{1'b0}};
      sync_fill_r <= {SYNC_STAGES{1'b0}};
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_active_in};
      sync_fill_r <= {sync_fill_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Decode the synchronised level, the fill marker and count saturation.
  always_comb begin
    cs_sync_s    = cs_sync_r[SYNC_STAGES-1];
    sync_ready_s = sync_fill_r[SYNC_STAGES-1];
    cnt_full_s   = &operand_count_r;
  end

  // Framing state machine. All outputs are registered here.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r          <= ST_IDLE;
      armed_r          <= 1'b0;
      op_code_r        <= 8'h00;
      op_code_valid_r  <= 1'b0;
      operand_r        <= 8'h00;
      operand_valid_r  <= 1'b0;
      operand_count_r  <= {COUNT_WIDTH{1'b0}};
      stray_byte_r     <= 1'b0;
      count_overflow_r <= 1'b0;
    end else begin
      operand_valid_r <= 1'b0;
      stray_byte_r    <= 1'b0;
      // A real low period on chip select re-arms the framer. This is what
      // makes the block skip the tail of a transaction cut by reset.
      if (!cs_sync_s && sync_ready_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (byte_valid_in) begin
            stray_byte_r <= 1'b1;
          end else begin
            stray_byte_r <= 1'b0;
          end
          if (cs_sync_s && armed_r) begin
            state_r <= ST_OPCODE;
            armed_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_OPCODE: begin
          if (byte_valid_in) begin
            op_code_r        <= byte_in;
            op_code_valid_r  <= 1'b1;
            operand_count_r  <= {COUNT_WIDTH{1'b0}};
            count_overflow_r <= 1'b0;
            state_r          <= ST_OPERAND;
          end else if (!cs_sync_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_OPCODE;
          end
        end
        ST_OPERAND: begin
          // The synchronised CS lags the pin, so a byte that arrives in the
          // cycle the drop is seen still belongs to this transaction.
          if (byte_valid_in) begin
            operand_r       <= byte_in;
            operand_valid_r <= 1'b1;
            if (cnt_full_s) begin
              count_overflow_r <= 1'b1;
            end else begin
              operand_count_r <= operand_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            operand_valid_r <= 1'b0;
          end
          if (!cs_sync_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_OPERAND;
          end
        end
        ST_DRAIN: begin
          if (byte_valid_in) begin
            stray_byte_r <= 1'b1;
          end else begin
            stray_byte_r <= 1'b0;
          end
          op_code_valid_r <= 1'b0;
          operand_count_r <= {COUNT_WIDTH{1'b0}};
          state_r         <= ST_IDLE;
        end
        default: begin
          op_code_valid_r <= 1'b0;
          operand_count_r <= {COUNT_WIDTH{1'b0}};
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_code_out        = op_code_r;
  assign op_code_valid_out  = op_code_valid_r;
  assign operand_out        = operand_r;
  assign operand_valid_out  = operand_valid_r;
  assign operand_count_out  = operand_count_r;
  assign stray_byte_out     = stray_byte_r;
  assign count_overflow_out = count_overflow_r;

endmodule

// File: tb/tb_spi_command_framer.sv
// Directed self-checking bench for spi_command_framer. A 32-bit count instance
// and a 3-bit count instance share the same stimulus; the narrow one covers
// count saturation.

module tb_spi_command_framer;

  logic       clock_in;
  logic       reset_in;
  logic       cs_active_in;
  logic [7:0] byte_in;
  logic       byte_valid_in;

  logic [7:0]  op_code;
  logic        op_code_valid;
  logic [7:0]  operand;
  logic        operand_valid;
  logic [31:0] operand_count;
  logic        stray_byte;
  logic        count_overflow;

  logic [7:0]  op_code3;
  logic        op_code_valid3;
  logic [7:0]  operand3;
  logic        operand_valid3;
  logic [2:0]  operand_count3;
  logic        stray_byte3;
  logic        count_overflow3;

  int n_checks = 0;
  int n_errors = 0;

  spi_command_framer #(.SYNC_STAGES(2), .COUNT_WIDTH(32)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .cs_active_in(cs_active_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .op_code_out(op_code), .op_code_valid_out(op_code_valid),
    .operand_out(operand), .operand_valid_out(operand_valid),
    .operand_count_out(operand_count), .stray_byte_out(stray_byte),
    .count_overflow_out(count_overflow)
  );

  spi_command_framer #(.SYNC_STAGES(2), .COUNT_WIDTH(3)) dut3 (
    .clock_in(clock_in), .reset_in(reset_in), .cs_active_in(cs_active_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .op_code_out(op_code3), .op_code_valid_out(op_code_valid3),
    .operand_out(operand3), .operand_valid_out(operand_valid3),
    .operand_count_out(operand_count3), .stray_byte_out(stray_byte3),
    .count_overflow_out(count_overflow3)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_in       = b;
    byte_valid_in = 1'b1;
    tick();
    byte_valid_in = 1'b0;
  endtask

  // Raise CS and wait until the framer is waiting for the op-code.
  task automatic cs_up(input string tag);
    cs_active_in = 1'b1;
    repeat (4) tick();
    chk({tag, "_preop_valid"}, {31'd0, op_code_valid}, 32'd1 - 32'd1);
  endtask

  // Drop CS (optionally with a last byte in the same cycle) and check the drain.
  task automatic drop_cs(input string tag, input bit last, input logic [7:0] lb,
                         input logic [31:0] lcnt);
    cs_active_in = 1'b0;
    if (last) begin
      byte_in       = lb;
      byte_valid_in = 1'b1;
    end
    tick();
    byte_valid_in = 1'b0;
    if (last) begin
      chk({tag, "_last_valid"}, {31'd0, operand_valid}, 32'd1);
      chk({tag, "_last_count"}, operand_count, lcnt);
      chk({tag, "_last_data"}, {24'd0, operand}, {24'd0, lb});
    end
    tick();
    chk({tag, "_lag_opvalid"}, {31'd0, op_code_valid}, 32'd1);
    tick();
    chk({tag, "_drain_opvalid"}, {31'd0, op_code_valid}, 32'd1);
    chk({tag, "_drain_operand_valid"}, {31'd0, operand_valid}, 32'd0);
    tick();
    chk({tag, "_idle_opvalid"}, {31'd0, op_code_valid}, 32'd0);
    chk({tag, "_idle_count"}, operand_count, 32'd0);
  endtask

  initial begin
    logic [7:0] ops4 [4];
    ops4[0] = 8'h03; ops4[1] = 8'hA0; ops4[2] = 8'h40; ops4[3] = 8'hE0;

    // Reset with CS held high.
    reset_in      = 1'b1;
    cs_active_in  = 1'b1;
    byte_in       = 8'h00;
    byte_valid_in = 1'b0;
    repeat (3) tick();
    chk("rst_opcode", {24'd0, op_code}, 32'd0);
    chk("rst_opvalid", {31'd0, op_code_valid}, 32'd0);
    chk("rst_operand", {24'd0, operand}, 32'd0);
    chk("rst_operand_valid", {31'd0, operand_valid}, 32'd0);
    chk("rst_count", operand_count, 32'd0);
    chk("rst_stray", {31'd0, stray_byte}, 32'd0);
    chk("rst_ovf", {31'd0, count_overflow}, 32'd0);
    reset_in = 1'b0;
    repeat (4) tick();
    send(8'h10);
    chk("postrst_stray", {31'd0, stray_byte}, 32'd1);
    chk("postrst_opvalid", {31'd0, op_code_valid}, 32'd0);
    tick();
    chk("postrst_stray_clear", {31'd0, stray_byte}, 32'd0);
    cs_active_in = 1'b0;
    repeat (4) tick();

    // Zero-operand command.
    cs_up("zero");
    send(8'h10);
    chk("zero_opcode", {24'd0, op_code}, 32'h10);
    chk("zero_opvalid", {31'd0, op_code_valid}, 32'd1);
    chk("zero_count", operand_count, 32'd0);
    drop_cs("zero", 1'b0, 8'h00, 32'd0);
    chk("zero_no_operand", {31'd0, operand_valid}, 32'd0);

    // Four-operand command.
    cs_up("four");
    send(8'h11);
    chk("four_opcode", {24'd0, op_code}, 32'h11);
    for (int i = 0; i < 4; i++) begin
      send(ops4[i]);
      chk("four_valid", {31'd0, operand_valid}, 32'd1);
      chk("four_count", operand_count, 32'(i + 1));
      chk("four_data", {24'd0, operand}, {24'd0, ops4[i]});
      chk("four_opvalid", {31'd0, op_code_valid}, 32'd1);
    end
    drop_cs("four", 1'b0, 8'h00, 32'd0);

    // Streaming: 20 back-to-back operands, a 21st coinciding with the CS fall.
    cs_up("stream");
    send(8'h12);
    for (int i = 0; i < 20; i++) begin
      send(8'h20 + 8'(i));
      chk("stream_valid", {31'd0, operand_valid}, 32'd1);
      chk("stream_count", operand_count, 32'(i + 1));
      chk("stream_data", {24'd0, operand}, 32'h20 + 32'(i));
    end
    drop_cs("stream", 1'b1, 8'h55, 32'd21);

    // CS pulse with no bytes.
    cs_active_in = 1'b1;
    repeat (4) tick();
    cs_active_in = 1'b0;
    repeat (4) tick();
    chk("pulse_opvalid", {31'd0, op_code_valid}, 32'd0);
    chk("pulse_operand_valid", {31'd0, operand_valid}, 32'd0);
    chk("pulse_opcode_hold", {24'd0, op_code}, 32'h12);
    chk("pulse_operand_hold", {24'd0, operand}, 32'h55);

    // Byte while idle.
    send(8'h77);
    chk("idle_stray", {31'd0, stray_byte}, 32'd1);
    tick();
    chk("idle_stray_once", {31'd0, stray_byte}, 32'd0);

    // Reset during operand 5 of 10.
    cs_up("midrst");
    send(8'h13);
    for (int i = 0; i < 4; i++) begin
      send(8'h60 + 8'(i));
    end
    chk("midrst_count4", operand_count, 32'd4);
    byte_in       = 8'h64;
    byte_valid_in = 1'b1;
    reset_in      = 1'b1;
    tick();
    reset_in      = 1'b0;
    byte_valid_in = 1'b0;
    chk("midrst_opvalid", {31'd0, op_code_valid}, 32'd0);
    chk("midrst_opcode", {24'd0, op_code}, 32'd0);
    chk("midrst_count", operand_count, 32'd0);
    chk("midrst_operand", {24'd0, operand}, 32'd0);
    for (int i = 5; i < 10; i++) begin
      send(8'h60 + 8'(i));
      chk("midrst_tail_stray", {31'd0, stray_byte}, 32'd1);
      chk("midrst_tail_opvalid", {31'd0, op_code_valid}, 32'd0);
      chk("midrst_tail_operand_valid", {31'd0, operand_valid}, 32'd0);
    end

    // CS low then high: the next transaction frames normally.
    cs_active_in = 1'b0;
    repeat (4) tick();
    cs_up("reframe");
    send(8'h14);
    chk("reframe_opcode", {24'd0, op_code}, 32'h14);
    chk("reframe_opvalid", {31'd0, op_code_valid}, 32'd1);
    send(8'h99);
    chk("reframe_count", operand_count, 32'd1);
    chk("reframe_data", {24'd0, operand}, 32'h99);
    drop_cs("reframe", 1'b0, 8'h00, 32'd0);

    // Saturation on the 3-bit instance: counts 1..7 then 7,7 with overflow.
    cs_up("sat");
    send(8'h15);
    chk("sat_ovf_clear_start", {31'd0, count_overflow3}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      send(8'hB0 + 8'(i));
      chk("sat_valid3", {31'd0, operand_valid3}, 32'd1);
      chk("sat_count3", {29'd0, operand_count3}, (i < 7) ? 32'(i + 1) : 32'd7);
      chk("sat_ovf3", {31'd0, count_overflow3}, (i < 7) ? 32'd0 : 32'd1);
      chk("sat_data3", {24'd0, operand3}, 32'hB0 + 32'(i));
      chk("sat_count32", operand_count, 32'(i + 1));
      chk("sat_ovf32", {31'd0, count_overflow}, 32'd0);
    end
    drop_cs("sat", 1'b0, 8'h00, 32'd0);
    chk("sat_ovf3_sticky", {31'd0, count_overflow3}, 32'd1);
    chk("sat_count3_idle", {29'd0, operand_count3}, 32'd0);
    cs_up("satnext");
    send(8'h16);
    chk("satnext_opcode3", {24'd0, op_code3}, 32'h16);
    chk("satnext_ovf3_cleared", {31'd0, count_overflow3}, 32'd0);
    drop_cs("satnext", 1'b0, 8'h00, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_command_framer.md
Name: spi_command_framer

Overview:
Sits directly upstream of the graphics command decoder. Takes the byte stream and chip-select framing from the SPI peripheral and converts each SPI transaction into graphics command-bus signals: an op-code held valid for the whole transaction, then single-cycle operand strobes with a running operand count. The first byte of a transaction is the op-code and every following byte is an operand. Each transaction is closed with a one-cycle drain, so the consumer always sees the last operand while the op-code is still valid.

Parameters:
SYNC_STAGES, 2, number of flops synchronising cs_active_in into clock_in (min 2)
COUNT_WIDTH, 32, width of operand_count_out; the count saturates at all-ones

Ports:
clock_in  input  1  system clock; the only clock
reset_in  input  1  synchronous, active-high reset
cs_active_in  input  1  transaction-active level from the SPI pin stage (asynchronous, active-high)
byte_in  input  8  received SPI byte, synchronous to clock_in
byte_valid_in  input  1  one-cycle strobe, byte_in valid
op_code_out  output  8  current op-code
op_code_valid_out  output  1  high from the cycle after op-code capture until the drain cycle completes
operand_out  output  8  latest operand byte
operand_valid_out  output  1  one-cycle strobe per operand
operand_count_out  output  COUNT_WIDTH  1-based index of the operand on operand_out
stray_byte_out  output  1  one-cycle pulse when a byte arrives outside a transaction
count_overflow_out  output  1  sticky; set when the count saturates, cleared when the next op-code is captured

Behaviour:
- Clock and reset: one clock (clock_in); reset_in is synchronous and active-high.
- Reset values:
  - All outputs are 0; state is IDLE; armed=0.
  - The synchroniser flops clear to 0.
- Chip select:
  - cs_sync is cs_active_in after SYNC_STAGES flops.
  - armed is set in any cycle where cs_sync==0.
  - A transaction starts only when armed=1. After a reset asserted mid-transaction, the block ignores the rest of that transaction until chip select drops and rises again.
- IDLE:
  - cs_sync==1 && armed: go to OPCODE and clear armed.
  - Any byte_valid_in in IDLE pulses stray_byte_out the following cycle; the byte is dropped.
- OPCODE:
  - On byte_valid_in: op_code_out <= byte_in, op_code_valid_out <= 1, operand_count_out <= 0, count_overflow_out <= 0, go to OPERAND. Latency from byte strobe to op_code_valid_out is 1 cycle.
  - If cs_sync==0 before any byte arrives: go to IDLE with no output change.
- OPERAND:
  - On byte_valid_in: operand_out <= byte_in, operand_valid_out <= 1 for exactly one cycle, and operand_count_out increments in that same registered cycle, so count and data are coherent with the strobe. Latency is 1 cycle.
  - Back-to-back strobes on consecutive cycles are each accepted; operand_valid_out stays high and the count increments every cycle.
  - On cs_sync==0: go to DRAIN. A byte_valid_in in that same cycle is still accepted as an operand, because cs_sync lags the pin.
- DRAIN (exactly 1 cycle):
  - op_code_valid_out stays 1 and operand_valid_out is 0.
  - Any byte arriving here is stray.
  - Next cycle: IDLE, op_code_valid_out <= 0, operand_count_out <= 0. op_code_out and operand_out hold their last values.
- Saturation:
  - If operand_count_out is all-ones when a new operand arrives, the count holds, count_overflow_out sets, and the operand is still strobed.
- Re-entry: chip select high again while in DRAIN is honoured from IDLE on the next cycle, since armed was set during the low period.
- A new op-code never appears without op_code_valid_out having been 0 for at least one cycle. This guarantees the consumer clears its per-command flags between commands.

Test Plan:
- Reset: hold reset_in for 3 cycles with cs_active_in=1 -> all outputs 0. After release with cs still high, byte 0x10 is ignored and stray_byte_out pulses.
- Zero-operand command: cs rises, byte 0x10 -> op_code_out=0x10 and op_code_valid_out=1 one cycle after the strobe. cs falls -> valid stays high for 1 drain cycle, then 0; no operand strobe.
- Four-operand command: cs rises, bytes 0x11,0x03,0xA0,0x40,0xE0 -> four operand_valid_out pulses with counts 1,2,3,4 and matching data; op_code_valid_out high throughout, then low after drain.
- Streaming: cs rises, 0x12 followed by 20 operand bytes on consecutive cycles -> operand_valid_out high for 20 consecutive cycles and counts 1..20. A last byte coinciding with the cs pin fall is still counted as 21.
- Framing edge cases:
  - cs pulse with no bytes -> no outputs.
  - A byte while idle -> stray_byte_out pulses once.
  - reset_in during operand 5 of 10 -> outputs 0 and the remaining bytes are stray.
  - cs toggled low then high -> the next transaction frames normally.
- Saturation: COUNT_WIDTH=3, 9 operands -> counts 1..7, then 7,7 with count_overflow_out=1. The next op-code clears the overflow flag.
